// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  // Arbiter frame states: accept a byte, pulse start, then track the busy rise and fall.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

  localparam int BYTE_W   = 8;
  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 9600;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin winner select (module rr_pick)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  logic [2*N_REQ-1:0] dbl_valid;
  logic [N_REQ-1:0]   rot_valid;
  logic [N_REQ-1:0]   rot_oh;
  logic [2*N_REQ-1:0] dbl_oh;
  logic [PTR_W-1:0]   rot_pos;
  logic [PTR_W:0]     idx_sum;
  logic               found;

  // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the one-hot back.
  always_comb begin
    dbl_valid = '0;
    rot_valid = '0;
    rot_oh    = '0;
    dbl_oh    = '0;
    rot_pos   = '0;
    idx_sum   = '0;
    found     = 1'b0;
    grant     = '0;
    index     = '0;

    dbl_valid = {req_valid, req_valid} >> ptr;
    rot_valid = dbl_valid[N_REQ-1:0];

    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot_valid[i]) begin
        found     = 1'b1;
        rot_oh[i] = 1'b1;
        rot_pos   = PTR_W'(i);
      end
    end

    dbl_oh = {rot_oh, rot_oh} << ptr;
    grant  = dbl_oh[2*N_REQ-1:N_REQ];

    idx_sum = {1'b0, rot_pos} + {1'b0, ptr};
    if (idx_sum >= (PTR_W+1)'(N_REQ)) begin
      idx_sum = idx_sum - (PTR_W+1)'(N_REQ);
    end
    index = idx_sum[PTR_W-1:0];
  end

  assign any = |req_valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter; ARB_WATCHDOG_EN adds a busy-rise watchdog
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = BYTE_W,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_start,
  input  logic                    tx_busy,
  output logic                    err_timeout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t         state_q;
  arb_state_t         state_d;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   idx_q;
  logic [N_REQ-1:0]   grant_q;
  logic [DATA_W-1:0]  tx_data_q;

  logic [N_REQ-1:0]   pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  logic               accept;
  logic               frame_done;
  logic               timeout;
  logic [PTR_W:0]     idx_inc;
  logic [PTR_W-1:0]   ptr_next;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (pick_oh),
    .index     (pick_idx),
    .any       (pick_any)
  );

  // A byte moves only while idle with the transmitter free; the frame ends on busy falling.
  assign accept     = (state_q == IDLE) && !tx_busy && pick_any;
  assign frame_done = (state_q == WAIT_DONE) && !tx_busy;

  // The pointer moves just past the owner of the finished (or abandoned) frame.
  assign idx_inc  = {1'b0, idx_q} + 1'b1;
  assign ptr_next = (idx_inc == (PTR_W+1)'(N_REQ)) ? '0 : idx_inc[PTR_W-1:0];

`ifdef ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0] wdog_q;

  // Count cycles spent in WAIT_BUSY; cleared whenever the FSM is elsewhere.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (state_q == WAIT_BUSY) begin
      wdog_q <= wdog_q + 1'b1;
    end else begin
      wdog_q <= '0;
    end
  end

  // Expiry happens on the last allowed WAIT_BUSY cycle if busy still has not risen.
  assign timeout = (state_q == WAIT_BUSY) && !tx_busy &&
                   (wdog_q == WD_W'(WDOG_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  assign err_timeout = timeout;

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the handshake and start-pulse outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    tx_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!tx_busy && pick_any) begin
          req_ready = pick_oh;
          state_d   = START;
        end
      end
      START: begin
        tx_start = 1'b1;
        state_d  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner's byte and owner on acceptance; release ownership at frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q   <= '0;
      tx_data_q <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
    end else begin
      if (accept) begin
        grant_q   <= pick_oh;
        tx_data_q <= req_data[pick_idx*DATA_W +: DATA_W];
        idx_q     <= pick_idx;
      end
      if (frame_done || timeout) begin
        grant_q <= '0;
        ptr_q   <= ptr_next;
      end
    end
  end

  assign grant   = grant_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] grant;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (4),
    .DATA_W      (8),
    .WDOG_CYCLES (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .err_timeout (err_timeout)
  );

  // Ownership must always be one-hot or empty.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      checks++;
      if ($isunknown(grant) || !$onehot0(grant)) begin
        failures++;
        $display("FAIL grant_onehot0 got=%b required=one-hot-or-zero", grant);
      end
`ifndef ARB_WATCHDOG_EN
      checks++;
      if (err_timeout !== 1'b0) begin
        failures++;
        $display("FAIL err_timeout_tied got=%b required=0", err_timeout);
      end
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic set_data(input int i, input logic [7:0] b);
    req_data[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    tx_busy   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL start_wait got=no_tx_start required=tx_start within 300 cycles");
    end
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty got=tx_start required=no frame");
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (tx_data !== e.data) begin
        failures++;
        $display("FAIL frame_data got=%h required=%h", tx_data, e.data);
      end
      checks++;
      if (grant !== e.grant) begin
        failures++;
        $display("FAIL frame_grant got=%b required=%b", grant, e.grant);
      end
    end
  endtask

  // Transmitter model: waits for start, checks the frame, holds busy for busy_len cycles.
  task automatic serve(input int busy_len);
    bit ok;
    int extra;
    wait_start(ok);
    if (ok) begin
      pop_check();
      @(negedge clk);
      extra = (tx_start === 1'b1) ? 1 : 0;
      tx_busy = 1'b1;
      repeat (busy_len) begin
        @(negedge clk);
        if (tx_start !== 1'b0) extra++;
      end
      tx_busy = 1'b0;
      checks++;
      if (extra != 0) begin
        failures++;
        $display("FAIL single_start got=%0d extra pulses required=0", extra);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    tx_busy   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    #3;
    checks++; if (grant !== 4'b0)       begin failures++; $display("FAIL reset_grant got=%b required=0000", grant); end
    checks++; if (tx_start !== 1'b0)    begin failures++; $display("FAIL reset_tx_start got=%b required=0", tx_start); end
    checks++; if (tx_data !== 8'h00)    begin failures++; $display("FAIL reset_tx_data got=%h required=00", tx_data); end
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", err_timeout); end
    checks++; if (req_ready !== 4'b0)   begin failures++; $display("FAIL reset_ready got=%b required=0000", req_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    set_data(2, 8'hA5);
    req_valid = 4'b0100;
    exp_q.push_back('{data: 8'hA5, grant: 4'b0100});
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready got=%b required=0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    set_data(2, 8'h00);
    checks++;
    if (tx_start !== 1'b1) begin
      failures++;
      $display("FAIL single_latency got=%b required=1", tx_start);
    end
    serve(4);
    repeat (2) @(negedge clk);
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL single_release got=%b required=0000", grant);
    end
  endtask

  task automatic test_round_robin();
    int stray;
    do_reset();
    set_data(0, 8'h11);
    set_data(1, 8'h22);
    set_data(2, 8'h33);
    set_data(3, 8'h44);
    req_valid = 4'b1111;
    exp_q.push_back('{data: 8'h11, grant: 4'b0001});
    exp_q.push_back('{data: 8'h22, grant: 4'b0010});
    exp_q.push_back('{data: 8'h33, grant: 4'b0100});
    exp_q.push_back('{data: 8'h44, grant: 4'b1000});
    exp_q.push_back('{data: 8'h11, grant: 4'b0001});
    for (int f = 0; f < 5; f++) serve(100);
    req_valid = 4'b0000;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_start !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL rr_no_extra_frame got=%0d starts required=0", stray);
    end
  endtask

  task automatic test_busy_in_idle();
    do_reset();
    tx_busy = 1'b1;
    set_data(0, 8'h3C);
    req_valid = 4'b0001;
    exp_q.push_back('{data: 8'h3C, grant: 4'b0001});
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000 || grant !== 4'b0000) begin
        failures++;
        $display("FAIL busy_idle_hold got=ready %b grant %b required=0000 0000", req_ready, grant);
      end
    end
    tx_busy = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL busy_idle_ready got=%b required=0001", req_ready);
    end
    @(negedge clk);
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL busy_idle_grant got=%b required=0001", grant);
    end
    req_valid = 4'b0000;
    serve(3);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    do_reset();
    set_data(1, 8'h61);
    req_valid = 4'b0010;
    exp_q.push_back('{data: 8'h61, grant: 4'b0010});
    @(negedge clk);
    req_valid = 4'b0000;
    serve(5);
    set_data(2, 8'h62);
    req_valid = 4'b0100;
    exp_q.push_back('{data: 8'h62, grant: 4'b0100});
    wait_start(ok);
    if (ok) pop_check();
    req_valid = 4'b0000;
    @(negedge clk);
    tx_busy = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL async_reset_grant got=%b required=0000", grant); end
    checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL async_reset_start got=%b required=0", tx_start); end
    tx_busy = 1'b0;
    set_data(0, 8'h70);
    set_data(3, 8'h73);
    req_valid = 4'b1001;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ptr_winner got=%b required=0001", req_ready);
    end
    exp_q.push_back('{data: 8'h70, grant: 4'b0001});
    @(negedge clk);
    req_valid = 4'b0000;
    serve(3);
  endtask

  task automatic test_drop_valid();
    bit ok;
    int stray;
    do_reset();
    set_data(0, 8'h5A);
    req_valid = 4'b0001;
    exp_q.push_back('{data: 8'h5A, grant: 4'b0001});
    @(negedge clk);
    req_valid = 4'b0000;
    wait_start(ok);
    if (ok) pop_check();
    @(negedge clk);
    tx_busy = 1'b1;
    set_data(3, 8'h77);
    req_valid = 4'b1000;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL drop_no_ready got=%b required=0000", req_ready);
      end
    end
    req_valid = 4'b0000;
    set_data(3, 8'h99);
    repeat (2) @(negedge clk);
    tx_busy = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (tx_start !== 1'b0) stray++;
    end
    checks++; if (stray != 0)        begin failures++; $display("FAIL drop_no_start got=%0d required=0", stray); end
    checks++; if (tx_data !== 8'h5A) begin failures++; $display("FAIL drop_tx_data got=%h required=5a", tx_data); end
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL drop_grant got=%b required=0000", grant); end
  endtask

`ifdef ARB_WATCHDOG_EN
  task automatic test_watchdog();
    bit ok;
    int n;
    do_reset();
    set_data(0, 8'h81);
    set_data(1, 8'h82);
    req_valid = 4'b0011;
    exp_q.push_back('{data: 8'h81, grant: 4'b0001});
    wait_start(ok);
    if (ok) pop_check();
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (err_timeout === 1'b1) break;
    end
    checks++;
    if (n != 64 || err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL wdog_cycles got=%0d err=%b required=64 1", n, err_timeout);
    end
    @(negedge clk);
    checks++; if (err_timeout !== 1'b0) begin failures++; $display("FAIL wdog_pulse_width got=%b required=0", err_timeout); end
    checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL wdog_next_req got=%b required=0010", req_ready); end
    exp_q.push_back('{data: 8'h82, grant: 4'b0010});
    @(negedge clk);
    req_valid = 4'b0000;
    serve(3);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_in_idle();
    test_reset_mid_frame();
    test_drop_valid();
`ifdef ARB_WATCHDOG_EN
    test_watchdog();
`endif
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
